// File: rtl/vram_scan_arbiter.sv
// One single-port video RAM shared by raster scanout and a host port.
// Scanout words are prefetched into a small FIFO ahead of the beam; the host gets the leftover cycles.
module vram_scan_arbiter #(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 16,
    parameter int PIX_PER_WORD = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int LOW_WATER    = 2,
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [8:0]        y,
    output logic              pixel,
    output logic              underflow,
    input  logic              hostReq,
    input  logic              hostWe,
    input  logic [ADDR_W-1:0] hostAddr,
    input  logic [DATA_W-1:0] hostWdata,
    output logic              hostAck,
    output logic [DATA_W-1:0] hostRdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);
    localparam int FRAME_WORDS = H_ACTIVE * V_ACTIVE / PIX_PER_WORD;
    localparam int PTR_W       = $clog2(FIFO_DEPTH);
    localparam int CNT_W       = PTR_W + 1;
    localparam int SUB_W       = $clog2(PIX_PER_WORD);

    localparam logic [ADDR_W-1:0] FRAME_END = ADDR_W'(FRAME_WORDS);
    localparam logic [CNT_W:0]    DEPTH_LVL = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W:0]    LOW_LVL   = (CNT_W + 1)'(LOW_WATER);

    logic [DATA_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] fetch_addr;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] rdata_hold;
    logic              vld_p0;
    logic              vld_p1;
    logic              host_p0;
    logic              ack_rd;

    logic [CNT_W:0]    level;
    logic              restart;
    logic              visible;
    logic              pop_point;
    logic              pop;
    logic              push;
    logic              video_ok;
    logic              host_ok;
    logic              grant_vid;
    logic              grant_host;

    assign head      = fifo_mem[rd_ptr];
    // Reads already issued but not yet pushed still reserve a FIFO slot.
    assign level     = {1'b0, count} + (CNT_W + 1)'(vld_p0) + (CNT_W + 1)'(vld_p1);
    assign restart   = (x == 10'd0) && (y == 9'(V_ACTIVE));
    assign visible   = (x < 10'(H_ACTIVE)) && (y < 9'(V_ACTIVE));
    assign pop_point = visible && (x[SUB_W-1:0] == '0);
    assign pop       = pop_point && (count != '0);
    assign push      = vld_p1 && !restart;

    assign video_ok   = !restart && (fetch_addr < FRAME_END) && (level < DEPTH_LVL);
    assign host_ok    = hostReq && !host_p0 && !hostAck;
    assign grant_vid  = video_ok && ((level < LOW_LVL) || !host_ok);
    assign grant_host = host_ok && !grant_vid;

    // Read data is only present on memRdata during the ack cycle; the hold register keeps it afterwards.
    assign hostRdata = ack_rd ? memRdata : rdata_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pixel      <= 1'b0;
            underflow  <= 1'b0;
            hostAck    <= 1'b0;
            ack_rd     <= 1'b0;
            rdata_hold <= '0;
            memEn      <= 1'b0;
            memWe      <= 1'b0;
            memAddr    <= '0;
            memWdata   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            fetch_addr <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            host_p0    <= 1'b0;
        end else begin
            // p0: access on the memory pins
            memEn   <= grant_vid || grant_host;
            memWe   <= grant_host && hostWe;
            vld_p0  <= grant_vid;
            host_p0 <= grant_host;
            if (grant_vid) begin
                memAddr <= fetch_addr;
            end else if (grant_host) begin
                memAddr  <= hostAddr;
                memWdata <= hostWdata;
            end

            // p1: memRdata valid, pushed or acked
            vld_p1  <= vld_p0 && !restart;
            hostAck <= host_p0;
            ack_rd  <= host_p0 && !memWe;
            if (ack_rd) begin
                rdata_hold <= memRdata;
            end

            if (restart) begin
                fetch_addr <= '0;
                wr_ptr     <= '0;
                rd_ptr     <= '0;
                count      <= '0;
                underflow  <= 1'b0;
            end else begin
                if (grant_vid) fetch_addr <= fetch_addr + ADDR_W'(1);
                if (push)      wr_ptr     <= wr_ptr + PTR_W'(1);
                if (pop)       rd_ptr     <= rd_ptr + PTR_W'(1);
                count <= count + CNT_W'(push) - CNT_W'(pop);
                if (pop_point && !pop) underflow <= 1'b1;
            end

            if (pop_point) begin
                pixel <= pop ? head[0] : 1'b0;
            end else if (visible) begin
                pixel <= shreg[0];
            end else begin
                pixel <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= memRdata;
        end
        if (pop_point) begin
            shreg <= pop ? (head >> 1) : '0;
        end else if (visible) begin
            shreg <= shreg >> 1;
        end
    end

endmodule
